result_tx: RTL and testbench

Downstream stage of the SSL top level. Consumes the three per-channel delay indices (A, B, C) produced by the processor arrays. Packs each result set into a 5-byte frame: SOF, A, B, C, checksum. Sends the frame over a UART 8N1 line to the host. Runs on the divided clock domain, so it shares clk with the counter and processor arrays.

---
 rtl/ssl_pkg.sv | 23 ++
 rtl/uart_tx_byte.sv | 90 +++++++++
 rtl/result_tx.sv | 73 +++++++
 tb/tb_result_tx.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/ssl_pkg.sv
// ssl_pkg: shared constants, state type and checksum helper for the SSL result path (TX_PARITY_EN adds the PARITY state)
package ssl_pkg;

    localparam logic [7:0] SOF_DEF     = 8'hA5;
    localparam int         FRAME_BYTES = 5;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef TX_PARITY_EN
        PARITY,
`endif
        STOP
    } tx_state_t;

    // XOR of every byte in the list that precedes the checksum
    function automatic logic [7:0] chk8(input logic [8*(FRAME_BYTES-1)-1:0] bytes);
        chk8 = '0;
        for (int i = 0; i < FRAME_BYTES - 1; i++) chk8 ^= bytes[8*i +: 8];
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: LSB-first UART byte serializer with load/ready handshake; 8E1 when TX_PARITY_EN is defined, else 8N1
module uart_tx_byte import ssl_pkg::*; #(
    parameter int BAUD_DIV = 104
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic       load,
    input  logic [7:0] data,
    output logic       txd,
    output logic       ready
);

    localparam int            CW   = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] CMAX = CW'(BAUD_DIV - 1);

    tx_state_t     state;
    logic [CW-1:0] cnt;
    logic [2:0]    bitn;
    logic [7:0]    sh;
    logic          bit_end;
`ifdef TX_PARITY_EN
    logic          par;
`endif

    assign bit_end = cnt == CMAX;
    // ready on the last stop cycle lets the next start bit follow with no gap
    assign ready   = state == IDLE || (state == STOP && bit_end);

    // one bit period per BAUD_DIV enabled cycles; txd is registered and set to the next bit on each boundary
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            bitn  <= '0;
            sh    <= '0;
            txd   <= 1'b1;
`ifdef TX_PARITY_EN
            par   <= 1'b0;
`endif
        end else if (ena) begin
            if (load && ready) begin
                state <= START;
                cnt   <= '0;
                bitn  <= '0;
                sh    <= data;
                txd   <= 1'b0;
`ifdef TX_PARITY_EN
                par   <= ^data;
`endif
            end else if (state != IDLE) begin
                cnt <= bit_end ? '0 : cnt + 1'b1;
                if (bit_end) begin
                    case (state)
                        START: begin
                            state <= DATA;
                            txd   <= sh[0];
                        end
                        DATA: begin
                            sh   <= sh >> 1;
                            bitn <= bitn + 1'b1;
                            if (bitn == 3'd7) begin
`ifdef TX_PARITY_EN
                                state <= PARITY;
                                txd   <= par;
`else
                                state <= STOP;
                                txd   <= 1'b1;
`endif
                            end else begin
                                txd <= sh[1];
                            end
                        end
`ifdef TX_PARITY_EN
                        PARITY: begin
                            state <= STOP;
                            txd   <= 1'b1;
                        end
`endif
                        default: begin
                            state <= IDLE;
                            txd   <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: rtl/result_tx.sv
// result_tx: frames each (A,B,C) result set as SOF,A,B,C,checksum and sends it over UART; define TX_PARITY_EN for 8E1
module result_tx import ssl_pkg::*; #(
    parameter  int         NDATA     = 128,
    parameter  int         BAUD_DIV  = 104,
    parameter  logic [7:0] SOF       = SOF_DEF,
    localparam int         NDATA_LOG = $clog2(NDATA)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic                 vld,
    input  logic [NDATA_LOG-1:0] din_a,
    input  logic [NDATA_LOG-1:0] din_b,
    input  logic [NDATA_LOG-1:0] din_c,
    output logic                 txd,
    output logic                 busy,
    output logic [7:0]           drop_cnt
);

    if (NDATA_LOG > 8) begin : g_ndata_chk
        $error("result_tx: NDATA_LOG must not exceed 8");
    end
    if (BAUD_DIV < 2) begin : g_baud_chk
        $error("result_tx: BAUD_DIV must be at least 2");
    end

    logic [7:0]                     a8, b8, c8, tx_byte;
    logic [8*(FRAME_BYTES-1)-1:0]   frame;
    logic [2:0]                     rem;
    logic                           ser_ready, load;

    assign a8      = 8'(din_a);
    assign b8      = 8'(din_b);
    assign c8      = 8'(din_c);
    // SOF goes straight out on accept; the remaining bytes shift out of the latched frame
    assign load    = busy ? ser_ready && rem != '0 : vld;
    assign tx_byte = busy ? frame[7:0] : SOF;

    uart_tx_byte #(.BAUD_DIV(BAUD_DIV)) u_ser (
        .clk   (clk),
        .rst   (rst),
        .ena   (ena),
        .load  (load),
        .data  (tx_byte),
        .txd   (txd),
        .ready (ser_ready)
    );

    // frame sequencer: latch the result set, feed one byte per serializer handshake, count sets arriving while busy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy     <= 1'b0;
            rem      <= '0;
            frame    <= '0;
            drop_cnt <= '0;
        end else if (ena) begin
            if (!busy && vld) begin
                busy  <= 1'b1;
                rem   <= 3'(FRAME_BYTES - 1);
                frame <= {chk8({c8, b8, a8, SOF}), c8, b8, a8};
            end else if (busy && ser_ready) begin
                if (rem != '0) begin
                    rem   <= rem - 1'b1;
                    frame <= frame >> 8;
                end else begin
                    busy <= 1'b0;
                end
            end
            if (busy && vld && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_result_tx.sv
// tb_result_tx: randomized bench for result_tx against a frame-timeline reference model
module tb_result_tx;

    localparam int BD    = 4;
    localparam int NDATA = 128;
    localparam int NL    = 7;
`ifdef TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int L = 5 * NB * BD;

    logic          clk = 1'b0, rst = 1'b1, ena = 1'b0, vld = 1'b0;
    logic [NL-1:0] din_a = '0, din_b = '0, din_c = '0;
    logic          txd, busy;
    logic [7:0]    drop_cnt;

    always #5 clk = ~clk;

    result_tx #(.NDATA(NDATA), .BAUD_DIV(BD), .SOF(8'hA5)) dut (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .vld      (vld),
        .din_a    (din_a),
        .din_b    (din_b),
        .din_c    (din_c),
        .txd      (txd),
        .busy     (busy),
        .drop_cnt (drop_cnt)
    );

    int checks = 0, errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference model: a frame is a list of bytes; position in it is the count of enabled cycles since accept
    logic       m_busy = 1'b0;
    int         m_e = 0, m_drop = 0;
    logic [7:0] m_fr [5];
    logic       s_txd, s_busy;

    function automatic logic exp_txd();
        int bi, pos;
        logic [7:0] b;
        if (!m_busy) return 1'b1;
        bi  = m_e / BD;
        pos = bi % NB;
        b   = m_fr[bi / NB];
        if (pos == 0) return 1'b0;
        if (pos <= 8) return b[pos-1];
        if (pos == 9 && NB == 11) return ^b;
        return 1'b1;
    endfunction

    function automatic logic [NL-1:0] rnd();
        return NL'($urandom);
    endfunction

    // check outputs for this cycle, drive inputs for the next edge, advance the model across that edge
    task automatic cyc(input logic v, input logic e, input logic [NL-1:0] a, input logic [NL-1:0] b, input logic [NL-1:0] c);
        logic [7:0] a8, b8, c8;
        check("txd", txd, exp_txd());
        check("busy", busy, m_busy);
        check("drop_cnt", drop_cnt, m_drop);
        s_txd  = txd;
        s_busy = busy;
        ena = e; vld = v; din_a = a; din_b = b; din_c = c;
        a8 = {1'b0, a}; b8 = {1'b0, b}; c8 = {1'b0, c};
        if (e) begin
            if (v && m_busy && m_drop < 255) m_drop++;
            if (m_busy) begin
                m_e++;
                if (m_e == L) m_busy = 1'b0;
            end else if (v) begin
                m_busy = 1'b1;
                m_e    = 0;
                m_fr   = '{8'hA5, a8, b8, c8, 8'hA5 ^ a8 ^ b8 ^ c8};
            end
        end
        @(posedge clk); #1;
    endtask

    logic       rec [L];
    logic [7:0] exp_bytes [5] = '{8'hA5, 8'h05, 8'h7F, 8'h00, 8'hDF};
    logic [7:0] got_b;
    int         bcnt;

    initial begin
        #2 rst = 1'b0;
        #1;
        check("reset_txd", txd, 1);
        check("reset_busy", busy, 0);
        check("reset_drop", drop_cnt, 0);
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk); #1;

        repeat (1000) cyc(0, 1, rnd(), rnd(), rnd());

        cyc(1, 1, 7'd5, 7'h7F, 7'd0);
        bcnt = 0;
        for (int k = 0; k < L; k++) begin
            cyc(k == 10 || k == 50 || k == L - 1, 1, rnd(), rnd(), rnd());
            rec[k] = s_txd;
            bcnt += int'(s_busy);
        end
        check("drops3", drop_cnt, 3);
        check("busy_len", bcnt, L);
        check("start_bit", rec[0], 0);
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 8; j++) got_b[j] = rec[(i * NB + 1 + j) * BD + BD / 2];
            check($sformatf("byte%0d", i), got_b, exp_bytes[i]);
        end

        cyc(1, 1, rnd(), rnd(), rnd());
        bcnt = 0;
        for (int k = 0; k < L + 20; k++) begin
            cyc(0, !(k >= 20 && k < 27), rnd(), rnd(), rnd());
            bcnt += int'(s_busy);
        end
        check("busy_len_ena", bcnt, L + 7);

        repeat (3000) cyc($urandom_range(0, 29) == 0, $urandom_range(0, 7) != 0, rnd(), rnd(), rnd());
        repeat (L + 2) cyc(0, 1, rnd(), rnd(), rnd());

        cyc(1, 1, rnd(), rnd(), rnd());
        repeat (60) cyc(0, 1, rnd(), rnd(), rnd());
        #3 rst = 1'b0;
        #1;
        check("arst_txd", txd, 1);
        check("arst_busy", busy, 0);
        check("arst_drop", drop_cnt, 0);
        m_busy = 1'b0; m_e = 0; m_drop = 0;
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk); #1;
        cyc(1, 1, rnd(), rnd(), rnd());
        repeat (L + 2) cyc(0, 1, rnd(), rnd(), rnd());

        repeat (800) cyc(1, 1, rnd(), rnd(), rnd());
        check("drop_sat", drop_cnt, 8'hFF);
        repeat (L + 2) cyc(0, 1, rnd(), rnd(), rnd());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
